counter_datapath_bank: RTL
==========================

// Module: counter_datapath_bank
// PURPOSE
//  Bank of CHANNELS independent up/down/load counters. Each channel feeds a registered
//  add/multiply/conditional datapath and a 3-stage pipelined bit-logic chain.
//  Used as a trace-heavy stimulus block: many live, derived, registered signals per
//  instance. Sits under a testbench top, one instance per generate iteration.
// PARAMETERS
//  CHANNELS   4     number of counter channels (>=1)
//  WIDTH      8     counter/datapath width in bits (>=6)
//  ADD_CONST  5     constant added to counter
//  MUL_CONST  3     multiplier applied to the add result
//  THRESH     100   threshold for the conditional-result select
// PORTS
//  clk           in   1              single clock, all logic on posedge
//  rst_n         in   1              synchronous reset, active low
//  en            in   1              run request
//  mode          in   2              00 hold, 01 up, 10 down, 11 load
//  chan_sel      in   $clog2(CHANNELS) target channel for load (min width 1)
//  load_val      in   WIDTH          value written on load
//  busy          out  1              FSM not in IDLE
//  counter_flat  out  CHANNELS*WIDTH counters, ch0 in LSBs
//  add_flat      out  CHANNELS*WIDTH registered counter+ADD_CONST
//  mul_flat      out  CHANNELS*WIDTH registered (counter+ADD_CONST)*MUL_CONST
//  cond_flat     out  CHANNELS*2*WIDTH registered conditional result
//  wrap_pulse    out  CHANNELS       1-cycle pulse on counter wrap
//  stage3        out  CHANNELS       3-stage pipelined logic output
//  res_valid     out  1              add/mul/cond valid
//  stage_valid   out  1              stage3 valid
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): all outputs and counters 0. FSM goes to IDLE. Pipelines are flushed.
//    Reset is honoured in any state, including mid-RUN or mid-DRAIN.
//  - FSM: IDLE -(en)-> RUN; RUN -(!en)-> DRAIN; DRAIN runs 3 cycles, then IDLE.
//    en=1 during DRAIN returns the FSM to RUN.
//  - Up/down steps by 1, applied only in RUN, to every channel.
//  - Load applies in any state, to chan_sel only; other channels hold. chan_sel>=CHANNELS: no effect.
//  - Wrap: up at 2^WIDTH-1 -> 0, and down at 0 -> 2^WIDTH-1, each raise wrap_pulse[i] for 1 cycle
//    (same edge as the counter update). Load never wraps.
//  - Datapath, 1 cycle after the counter value c (all arithmetic truncated to WIDTH):
//    a=c+ADD_CONST; m=a*MUL_CONST;
//    cond = (c>THRESH) ? {a,m} & {{WIDTH{1}},{WIDTH{0}}}
//                      : {m,a} | {{WIDTH{0}},{WIDTH{1}}}.
//  - Stage chain, registered each stage, carrying the counter bits it needs:
//    s1=c[0]^c[1]; s2=(s1|c[2])^c[3]; s3=s2&(c[4]|~c[5]); latency 3 from c.
//  - res_valid: 1 cycle after a RUN cycle. stage_valid: 3 cycles after a RUN cycle.
//    Both deassert as the pipeline drains.
//  - Counters hold when mode=00, or when not in RUN (except load).
// CONFIGURATION
//  COUNTER_BANK_PARITY_EN defined:
//    - adds output parity_err[CHANNELS].
//    - a parity bit is registered alongside each counter.
//    - a per-channel input inj_par[CHANNELS] flips the stored parity.
//    - parity_err[i] is the registered mismatch, 1 cycle later.
//  Not defined: none of these ports or logic exist; the rest of the behaviour is identical.
// TESTING
//  1 rst_n=0 for 2 cycles with en=1 -> counters=0, busy=0, res_valid=0, wrap_pulse=0.
//  2 en=1, mode=01 from reset, 3 RUN cycles -> ch0 counter=3.
//    The cycle after counter=2: add=7, mul=21, res_valid=1.
//  3 load ch1=255 (mode=11), then up -> ch1=0, wrap_pulse=4'b0010 for 1 cycle, other channels +1.
//  4 ch0=0, mode=10 -> ch0=255, wrap_pulse[0]=1.
//  5 load 101 -> cond=16'h6A00. Load 100 -> cond=16'h3BFF.
//  6 en dropped in RUN -> busy=1 for 3 cycles, then 0; stage_valid falls.
//    rst_n=0 mid-RUN -> IDLE and all zeros at the next edge.

Source files
------------

// File: rtl/counter_datapath_bank.sv
// Bank of CHANNELS up/down/load counters, each feeding a registered add/mul/cond
// datapath and a 3-stage logic chain. Optional stored parity: COUNTER_BANK_PARITY_EN.
module counter_datapath_bank #(
  parameter int CHANNELS  = 4,
  parameter int WIDTH     = 8,
  parameter int ADD_CONST = 5,
  parameter int MUL_CONST = 3,
  parameter int THRESH    = 100
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            en,
  input  logic [1:0]                                      mode,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] chan_sel,
  input  logic [WIDTH-1:0]                                load_val,
  output logic                                            busy,
  output logic [CHANNELS*WIDTH-1:0]                       counter_flat,
  output logic [CHANNELS*WIDTH-1:0]                       add_flat,
  output logic [CHANNELS*WIDTH-1:0]                       mul_flat,
  output logic [CHANNELS*2*WIDTH-1:0]                     cond_flat,
  output logic [CHANNELS-1:0]                             wrap_pulse,
  output logic [CHANNELS-1:0]                             stage3,
  output logic                                            res_valid,
  output logic                                            stage_valid
`ifdef COUNTER_BANK_PARITY_EN
  ,
  input  logic [CHANNELS-1:0]                             inj_par,
  output logic [CHANNELS-1:0]                             parity_err
`endif
);

  localparam int SELW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN} state_e;

  state_e     state_q;
  logic [1:0] drain_q;
  logic       busy_q;
  logic       run;
  logic       res_valid_q;
  logic [2:0] sv_q;

  assign run = (state_q == ST_RUN);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (en) begin
          state_q <= ST_RUN;
          busy_q  <= 1'b1;
        end
        ST_RUN: if (!en) begin
          state_q <= ST_DRAIN;
          drain_q <= '0;
        end
        ST_DRAIN: begin
          if (en) begin
            state_q <= ST_RUN;
          end else if (drain_q == 2'd2) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Valid flags follow the RUN cycle through the same depth as the data they qualify.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_valid_q <= 1'b0;
      sv_q        <= '0;
    end else begin
      res_valid_q <= run;
      sv_q        <= {sv_q[1:0], run};
    end
  end

  assign busy        = busy_q;
  assign res_valid   = res_valid_q;
  assign stage_valid = sv_q[2];

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [WIDTH-1:0]   cnt_q, cnt_d, add_q, add_d, mul_q, mul_d;
    logic [2*WIDTH-1:0] cond_q, cond_d;
    logic               wrap_q, wrap_d;
    logic               s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [5:2]         c1_q;
    logic [5:4]         c2_q;
    logic               load_hit;

    assign load_hit = (mode == 2'b11) && (chan_sel == SELW'(g));

    always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (load_hit) begin
        cnt_d = load_val;
      end else if (run && mode == 2'b01) begin
        cnt_d  = cnt_q + WIDTH'(1);
        wrap_d = (cnt_q == '1);
      end else if (run && mode == 2'b10) begin
        cnt_d  = cnt_q - WIDTH'(1);
        wrap_d = (cnt_q == '0);
      end
      add_d  = cnt_q + WIDTH'(ADD_CONST);
      mul_d  = add_d * WIDTH'(MUL_CONST);
      cond_d = (cnt_q > WIDTH'(THRESH))
             ? ({add_d, mul_d} & {{WIDTH{1'b1}}, {WIDTH{1'b0}}})
             : ({mul_d, add_d} | {{WIDTH{1'b0}}, {WIDTH{1'b1}}});
      s1_d   = cnt_q[0] ^ cnt_q[1];
      s2_d   = (s1_q | c1_q[2]) ^ c1_q[3];
      s3_d   = s2_q & (c2_q[4] | ~c2_q[5]);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        cnt_q  <= '0;
        add_q  <= '0;
        mul_q  <= '0;
        cond_q <= '0;
        wrap_q <= 1'b0;
        s1_q   <= 1'b0;
        s2_q   <= 1'b0;
        s3_q   <= 1'b0;
        c1_q   <= '0;
        c2_q   <= '0;
      end else begin
        cnt_q  <= cnt_d;
        add_q  <= add_d;
        mul_q  <= mul_d;
        cond_q <= cond_d;
        wrap_q <= wrap_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
        s3_q   <= s3_d;
        c1_q   <= cnt_q[5:2];
        c2_q   <= c1_q[5:4];
      end
    end

    assign counter_flat[g*WIDTH +: WIDTH]     = cnt_q;
    assign add_flat[g*WIDTH +: WIDTH]         = add_q;
    assign mul_flat[g*WIDTH +: WIDTH]         = mul_q;
    assign cond_flat[g*2*WIDTH +: 2*WIDTH]    = cond_q;
    assign wrap_pulse[g]                      = wrap_q;
    assign stage3[g]                          = s3_q;

`ifdef COUNTER_BANK_PARITY_EN
    logic par_q, par_d, perr_q, perr_d;

    always_comb begin
      par_d  = (^cnt_d) ^ inj_par[g];
      perr_d = par_q ^ (^cnt_q);
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        par_q  <= 1'b0;
        perr_q <= 1'b0;
      end else begin
        par_q  <= par_d;
        perr_q <= perr_d;
      end
    end

    assign parity_err[g] = perr_q;
`endif
  end

endmodule
